// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous RAM between the IF-stage fetch port and
//   the MEM-stage load/store port. Each granted access holds the RAM control
//   lines for WAIT_CYCLES cycles and then returns a one-cycle ack pulse on the
//   owning port. Stall outputs are combinational so the pipeline freezes while
//   a request is outstanding or waiting for the RAM.
//
// Ports
//   clk, rstb                  clock, asynchronous active-low reset
//   if_req/if_addr             fetch request (held until if_ack) and address
//   if_ack/if_rdata            fetch completion pulse and fetch data
//   mem_req/mem_we/mem_addr/   load/store request (held until mem_ack),
//   mem_wdata                  direction, address and store data
//   mem_ack/mem_rdata          load/store completion pulse and load data
//   ram_oe/ram_we/ram_addr/    RAM control, address and write data
//   ram_din, ram_dout          (driven only during ACCESS), RAM read data
//   stall_if/stall_mem         pending request not yet acknowledged
//   busy                       arbiter is not idle
module mem_port_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_oe,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t              r_state;
  state_t              w_state_next;
  logic [3:0]          r_cnt;
  logic                r_owner_mem;  // 1 = MEM port owns the current access
  logic                r_last_mem;   // 1 = most recent grant went to MEM
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_we;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_if_ack;
  logic                r_mem_ack;

  logic                w_any_req;
  logic                w_grant_mem;
  logic                w_last_beat;
  logic                w_access;

  // On a tie the port that did not win last time is served.
  assign w_any_req   = if_req | mem_req;
  assign w_grant_mem = mem_req & (~if_req | ~r_last_mem);
  assign w_last_beat = (r_cnt == 4'd1);
  assign w_access    = (r_state == S_ACCESS);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_state_next = S_ACCESS;
      S_ACCESS: if (w_last_beat) w_state_next = S_RESP;
      S_RESP:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_owner_mem <= 1'b0;
      r_last_mem  <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_rdata     <= '0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      // Acks are only ever high for the single RESP cycle.
      r_if_ack  <= 1'b0;
      r_mem_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner_mem <= w_grant_mem;
            r_last_mem  <= w_grant_mem;
            r_addr      <= w_grant_mem ? mem_addr : if_addr;
            if (w_grant_mem) r_wdata <= mem_wdata;
            r_we        <= w_grant_mem & mem_we;
            r_cnt       <= WAIT_LOAD;
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt - 4'd1;
          if (w_last_beat) begin
            // Stores leave the read-data register untouched.
            if (!r_we) r_rdata <= ram_dout;
            r_if_ack  <= ~r_owner_mem;
            r_mem_ack <= r_owner_mem;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM controls are decoded from state so an asynchronous reset drops them
  // in the same instant, aborting any access in flight.
  assign ram_oe    = w_access & ~r_we;
  assign ram_we    = w_access & r_we;
  assign ram_addr  = w_access ? r_addr  : '0;
  assign ram_din   = w_access ? r_wdata : '0;

  assign if_ack    = r_if_ack;
  assign mem_ack   = r_mem_ack;
  assign if_rdata  = r_rdata;
  assign mem_rdata = r_rdata;

  assign stall_if  = if_req  & ~r_if_ack;
  assign stall_mem = mem_req & ~r_mem_ack;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous data/instruction RAM between the IF-stage fetch port and the MEM-stage load/store port of the pipelined processor.
- Sequences each access through a fixed number of wait-state cycles and returns data with a one-cycle ack pulse.
- Drives combinational stall signals so the pipeline holds while an access is outstanding or denied.

Parameters:
- WAIT_CYCLES, 2, cycles the RAM control lines are held per access; legal range 1..15.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rstb  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid.
- if_rdata  out  DATA_W  fetch data.
- mem_req  in  1  load/store request; held until mem_ack.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  ADDR_W  load/store address.
- mem_wdata  in  DATA_W  store data.
- mem_ack  out  1  one-cycle pulse: load/store complete.
- mem_rdata  out  DATA_W  load data.
- ram_oe  out  1  RAM output enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_dout  in  DATA_W  RAM read data.
- stall_if  out  1  if_req & ~if_ack.
- stall_mem  out  1  mem_req & ~mem_ack.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rstb=0, asynchronous): state=IDLE, wait counter=0, owner=IF, last_grant=IF, latched addr/wdata/we=0, rdata register=0.
- Reset outputs: if_ack, mem_ack, ram_oe, ram_we = 0; ram_addr, ram_din, if_rdata, mem_rdata = 0; busy = 0.
- Reset mid-access aborts the access: no ack is issued, and RAM controls drop immediately.
- IDLE state:
  - Request only on mem_req: grant MEM.
  - Request only on if_req: grant IF.
  - Both requesting: grant the port that is not last_grant. Since last_grant resets to IF, the first tie goes to MEM.
  - On grant: latch owner, address, wdata (MEM only), we (IF grants force we=0); update last_grant; load counter=WAIT_CYCLES; go to ACCESS.
  - No request: stay in IDLE.
- ACCESS state:
  - ram_addr and ram_din come from the latched values and are stable for all WAIT_CYCLES cycles.
  - ram_we = latched we; ram_oe = ~latched we.
  - Counter decrements each cycle. In the cycle where counter==1, a load captures ram_dout into the rdata register, then the state goes to RESP.
- RESP state:
  - Owner's ack = 1 for exactly this cycle; RAM controls = 0; next state IDLE.
- Latency: request sampled at edge k → ack high in cycle k+WAIT_CYCLES+1. Minimum issue interval per port is WAIT_CYCLES+2 cycles.
- Outside ACCESS: ram_oe = ram_we = 0, ram_addr = ram_din = 0.
- if_rdata and mem_rdata are both driven from the rdata register. They are valid only while the corresponding ack is high; a store leaves the rdata register unchanged.
- Requester inputs that change after grant are ignored. A request dropped mid-access still completes and still receives its ack pulse.
- A req still high in the IDLE cycle after its ack is treated as a new request.
- Ack is one-hot: the non-owner's ack is always 0.
- stall_if, stall_mem and busy are combinational. Acks and rdata are registered.

Test Plan:
- WAIT_CYCLES=2; mem_req=1, mem_we=1, addr=0x40, wdata=0xDEADBEEF at edge 0 → ram_we=1 with addr 0x40 in cycles 1–2, ram_oe=0; mem_ack pulse in cycle 3; stall_mem=1 in cycles 0–2.
- Load addr 0x40 (RAM returns 0xDEADBEEF) → ram_oe=1 in cycles 1–2; mem_ack and mem_rdata=0xDEADBEEF in cycle 3; if_ack stays 0.
- if_req and mem_req both asserted and held after reset → grant order MEM, IF, MEM, IF, with ack pulses every 4 cycles; stall of the waiting port stays 1 until its ack.
- Fetch at 0x100 with a different if_addr and a mem_req arriving during ACCESS → RAM still sees 0x100; if_ack and data delivered first; MEM is granted in the following IDLE cycle.
- rstb pulled low in the second ACCESS cycle of a store → ram_we=0 immediately, no ack, busy=0; after release the first request is serviced normally.
- WAIT_CYCLES=1 and 15 → ack appears exactly 2 and 16 cycles after the request edge; ram_addr is stable for the whole window.
